// File: rtl/vjtag_scan_pkg.sv
// Shared types and constants for the virtual-JTAG scan master.
package vjtag_scan_pkg;

  localparam int unsigned DR_WIDTH_DEFAULT = 38;
  localparam int unsigned IR_WIDTH_DEFAULT = 2;

  // Virtual instruction codes understood by the CPU debug module
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    DONE
  } state_e;

endpackage

// File: rtl/vjtag_tck_gen.sv
// TCK divider: each enabled period is TCK_DIV clk low followed by TCK_DIV clk high.
// rise_o marks the clk edge that drives TCK high, period_end_o the edge that ends the period.
module vjtag_tck_gen #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic period_end_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       high_q, high_d;
  logic       half_end;

  assign half_end = (cnt_q == 8'(TCK_DIV - 1));

  // Half-period counter; parked at low phase, count 0 while disabled
  always_comb begin
    cnt_d  = cnt_q;
    high_d = high_q;
    if (!en_i) begin
      cnt_d  = '0;
      high_d = 1'b0;
    end else if (half_end) begin
      cnt_d  = '0;
      high_d = ~high_q;
    end else begin
      cnt_d  = cnt_q + 8'd1;
    end
  end

  // Divider state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
    end
  end

  assign tck_o        = high_q;
  assign rise_o       = en_i && !high_q && half_end;
  assign period_end_o = en_i && high_q && half_end;

endmodule

// File: rtl/vjtag_scan_master.sv
// Virtual-JTAG scan master: loads the IR, then shifts a DR_WIDTH-bit data register
// LSB first and returns the captured TDO word.
// Optional feature macro: VJTAG_SCAN_SKIP_IR_EN (skip UIR when the IR is unchanged).
module vjtag_scan_master
  import vjtag_scan_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEFAULT,
  parameter int unsigned TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned BW = $clog2(DR_WIDTH + 1);

  state_e              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d;
  logic [DR_WIDTH-1:0] rx_q, rx_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                rsp_valid_q;
  logic [DR_WIDTH-1:0] rsp_dr_q;
  logic                tck_en, tck_rise, period_end;
  logic                skip_ir;

`ifdef VJTAG_SCAN_SKIP_IR_EN
  // ir_q only changes on the UIR path, so it is exactly the last loaded IR
  logic [IR_WIDTH-1:0] last_ir;
  assign last_ir = ir_q;
  assign skip_ir = (cmd_ir == last_ir);
`else
  assign skip_ir = 1'b0;
`endif

  assign tck_en = (state_q != IDLE) && (state_q != DONE);

  vjtag_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .en_i        (tck_en),
    .tck_o       (vji_tck),
    .rise_o      (tck_rise),
    .period_end_o(period_end)
  );

  // Next-state and shift-register datapath
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ir_d    = cmd_ir;
          tx_d    = cmd_dr;
          rx_d    = '0;
          state_d = skip_ir ? CDR : UIR;
        end
      end
      UIR: if (period_end) state_d = CDR;
      CDR: begin
        if (period_end) begin
          state_d = SDR;
          bit_d   = BW'(DR_WIDTH - 1);
        end
      end
      SDR: begin
        if (tck_rise) rx_d = {vji_tdo, rx_q[DR_WIDTH-1:1]};
        if (period_end) begin
          tx_d = tx_q >> 1;
          if (bit_q == '0) state_d = UDR;
          else             bit_d   = bit_q - BW'(1);
        end
      end
      UDR:  if (period_end) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
    end
  end

  // Response register: one-clk valid pulse, word held until the next completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_dr_q    <= '0;
    end else begin
      rsp_valid_q <= (state_q == DONE);
      if (state_q == DONE) rsp_dr_q <= rx_q;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign vji_rti   = (state_q == IDLE);
  assign vji_uir   = (state_q == UIR);
  assign vji_cdr   = (state_q == CDR);
  assign vji_sdr   = (state_q == SDR);
  assign vji_udr   = (state_q == UDR);
  assign vji_tdi   = (state_q == SDR) && tx_q[0];
  assign vji_ir_in = ir_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = rsp_dr_q;

endmodule

// File: tb/tb_vjtag_scan_master.sv
// Bench for vjtag_scan_master (DR_WIDTH=38, IR_WIDTH=2, TCK_DIV=4).
`timescale 1ns/1ps
module tb_vjtag_scan_master;
  import vjtag_scan_pkg::*;

  localparam int unsigned DRW = 38;
  localparam int unsigned IRW = 2;
  localparam int unsigned DIV = 4;
  localparam int unsigned PER = 2 * DIV;
`ifdef VJTAG_SCAN_SKIP_IR_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DRW-1:0] cmd_dr = '0;
  logic           cmd_ready, rsp_valid;
  logic [DRW-1:0] rsp_dr;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [IRW-1:0] vji_ir_in;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [1:0]     tdo_mode = 2'd0;   // 0: tie 0, 1: tie 1, 2: loopback, 3: inverted loopback

  always #5 clk = ~clk;

  vjtag_scan_master #(
    .DR_WIDTH(DRW),
    .IR_WIDTH(IRW),
    .TCK_DIV (DIV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ir   (cmd_ir),
    .cmd_dr   (cmd_dr),
    .rsp_valid(rsp_valid),
    .rsp_dr   (rsp_dr),
    .vji_tck  (vji_tck),
    .vji_tdi  (vji_tdi),
    .vji_tdo  (vji_tdo),
    .vji_ir_in(vji_ir_in),
    .vji_uir  (vji_uir),
    .vji_cdr  (vji_cdr),
    .vji_sdr  (vji_sdr),
    .vji_udr  (vji_udr),
    .vji_rti  (vji_rti)
  );

  // TDO source: previous TCK period's TDI (loopback) or constants
  logic sampled_tdi = 1'b0, prev_tdi = 1'b0;
  always @(posedge vji_tck) sampled_tdi <= vji_tdi;
  always @(negedge vji_tck) prev_tdi <= sampled_tdi;
  assign vji_tdo = (tdo_mode == 2'd0) ? 1'b0 :
                   (tdo_mode == 2'd1) ? 1'b1 :
                   (tdo_mode == 2'd2) ? prev_tdi : ~prev_tdi;

  // Monitors
  int unsigned cyc = 0, acc_cnt = 0, acc_cyc = 0;
  int unsigned n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_tckhi = 0;
  int unsigned n_zero = 0, n_multi = 0, n_tdi_bad = 0, n_rsp = 0;
  logic [DRW-1:0] tdi_log = '0;
  logic [2:0] strobe_sum;
  assign strobe_sum = 3'(vji_uir) + 3'(vji_cdr) + 3'(vji_sdr) + 3'(vji_udr) + 3'(vji_rti);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc + 1;
    end
  end

  always @(posedge vji_tck) if (vji_sdr) tdi_log <= {vji_tdi, tdi_log[DRW-1:1]};

  always @(negedge clk) begin
    if (vji_uir) n_uir <= n_uir + 1;
    if (vji_cdr) n_cdr <= n_cdr + 1;
    if (vji_sdr) n_sdr <= n_sdr + 1;
    if (vji_udr) n_udr <= n_udr + 1;
    if (vji_tck) n_tckhi <= n_tckhi + 1;
    if (strobe_sum == 3'd0) n_zero <= n_zero + 1;
    if (strobe_sum > 3'd1) n_multi <= n_multi + 1;
    if (vji_tdi && !vji_sdr) n_tdi_bad <= n_tdi_bad + 1;
    if (rsp_valid) n_rsp <= n_rsp + 1;
  end

  // Checking state
  int unsigned n_pass = 0, n_total = 0;
  logic [DRW-1:0] exp_q[$];
  logic [IRW-1:0] model_last_ir = '0;

  typedef struct {
    logic [IRW-1:0] ir;
    logic [DRW-1:0] dr;
    logic [1:0]     mode;
    logic [DRW-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Bit-serial model of the captured word for a given TDO source
  function automatic logic [DRW-1:0] model_rx(input logic [DRW-1:0] dr, input logic [1:0] mode);
    logic [DRW-1:0] r;
    logic prev;
    r = '0;
    prev = 1'b0;
    for (int unsigned k = 0; k < DRW; k++) begin
      case (mode)
        2'd0:    r[k] = 1'b0;
        2'd1:    r[k] = 1'b1;
        2'd2:    r[k] = prev;
        default: r[k] = ~prev;
      endcase
      prev = dr[k];
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, ".strobes"}, 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'b00001);
    chk({tag, ".tck_tdi"}, 64'({vji_tck, vji_tdi}), 64'd0);
    chk({tag, ".ir_in"}, 64'(vji_ir_in), 64'd0);
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, ".rsp_dr"}, 64'(rsp_dr), 64'd0);
  endtask

  // Wait for ready, present one command for one accept edge; returns #1 after that edge
  task automatic send(input string tag, input logic [IRW-1:0] ir, input logic [DRW-1:0] dr, input bit hold);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    chk({tag, ".ready_timeout"}, 64'(ok), 64'd1);
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output int unsigned rcyc);
    bit ok;
    ok = 1'b0;
    rcyc = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; rcyc = cyc; break; end
    end
    chk({tag, ".rsp_timeout"}, 64'(ok), 64'd1);
    if (ok) begin
      if (exp_q.size() == 0) chk({tag, ".unexpected_rsp"}, 64'(exp_q.size()), 64'd1);
      else chk({tag, ".rsp_dr"}, 64'(rsp_dr), 64'(exp_q.pop_front()));
    end
    #1;
  endtask

  // One full scan with strobe, TDI, TCK and latency checks
  task automatic run_scan(input string tag, input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                          input logic [1:0] mode, input logic [DRW-1:0] exp);
    int unsigned s_uir, s_cdr, s_sdr, s_udr, s_tck, s_zero, s_multi, s_bad, s_rsp, a_cyc, r_cyc;
    bit skip;
    skip = SKIP_EN && (ir == model_last_ir);
    model_last_ir = ir;
    tdo_mode = mode;
    send(tag, ir, dr, 1'b0);
    exp_q.push_back(exp);
    a_cyc = acc_cyc;
    s_uir = n_uir; s_cdr = n_cdr; s_sdr = n_sdr; s_udr = n_udr; s_tck = n_tckhi;
    s_zero = n_zero; s_multi = n_multi; s_bad = n_tdi_bad; s_rsp = n_rsp;
    chk({tag, ".busy"}, 64'(cmd_ready), 64'd0);
    wait_rsp(tag, r_cyc);
    chk({tag, ".latency"}, 64'(r_cyc - a_cyc), skip ? 64'((DRW + 2) * PER + 1) : 64'((DRW + 3) * PER + 1));
    chk({tag, ".ready_back"}, 64'(cmd_ready), 64'd1);
    chk({tag, ".uir_clks"}, 64'(n_uir - s_uir), skip ? 64'd0 : 64'(PER));
    chk({tag, ".cdr_clks"}, 64'(n_cdr - s_cdr), 64'(PER));
    chk({tag, ".sdr_clks"}, 64'(n_sdr - s_sdr), 64'(DRW * PER));
    chk({tag, ".udr_clks"}, 64'(n_udr - s_udr), 64'(PER));
    chk({tag, ".tck_high_clks"}, 64'(n_tckhi - s_tck), skip ? 64'((DRW + 2) * DIV) : 64'((DRW + 3) * DIV));
    chk({tag, ".no_strobe_clks"}, 64'(n_zero - s_zero), 64'd1);
    chk({tag, ".strobe_overlap"}, 64'(n_multi - s_multi), 64'd0);
    chk({tag, ".tdi_outside_sdr"}, 64'(n_tdi_bad - s_bad), 64'd0);
    chk({tag, ".tdi_sequence"}, 64'(tdi_log), 64'(dr));
    chk({tag, ".ir_in"}, 64'(vji_ir_in), 64'(ir));
    chk({tag, ".rsp_pulses"}, 64'(n_rsp - s_rsp), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r1, r2, a1, s_acc, s_rsp, s_sdr;
    logic [DRW-1:0] rnd;
    bit ok;

    vecs[0] = '{IR_BREAK,     38'h15_5555_5555, 2'd1, 38'h3F_FFFF_FFFF};
    vecs[1] = '{IR_OCIMEM,    38'h00_0000_0001, 2'd2, 38'h00_0000_0002};
    vecs[2] = '{IR_TRACECTRL, 38'h3F_FFFF_FFFF, 2'd0, 38'h00_0000_0000};
    vecs[3] = '{IR_TRACEMEM,  38'h12_3456_789A, 2'd2, 38'h24_68AC_F134};
    vecs[4] = '{IR_TRACEMEM,  38'h0A_5A5A_5A5A, 2'd3, model_rx(38'h0A_5A5A_5A5A, 2'd3)};
    rnd = 38'({$urandom, $urandom});
    vecs[5] = '{IR_BREAK, rnd, 2'd2, model_rx(rnd, 2'd2)};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Table-driven scans
    for (int i = 0; i < 6; i++)
      run_scan($sformatf("vec%0d", i), vecs[i].ir, vecs[i].dr, vecs[i].mode, vecs[i].exp);

    // cmd_valid held: one accept per scan, second accepted right after rsp_valid
    tdo_mode = 2'd1;
    s_acc = acc_cnt;
    send("hold", IR_BREAK, 38'h01_0203_0405, 1'b1);
    exp_q.push_back('1);
    a1 = acc_cyc;
    chk("hold.first_accepts", 64'(acc_cnt - s_acc), 64'd1);
    wait_rsp("hold.first", r1);
    chk("hold.first_latency", 64'(r1 - a1),
        (SKIP_EN && model_last_ir == IR_BREAK) ? 64'((DRW + 2) * PER + 1) : 64'((DRW + 3) * PER + 1));
    model_last_ir = IR_BREAK;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    exp_q.push_back('1);
    chk("hold.second_accept_cyc", 64'(acc_cyc), 64'(r1 + 1));
    chk("hold.accepts", 64'(acc_cnt - s_acc), 64'd2);
    wait_rsp("hold.second", r2);
    chk("hold.second_latency", 64'(r2 - (r1 + 1)), SKIP_EN ? 64'((DRW + 2) * PER + 1) : 64'((DRW + 3) * PER + 1));
    repeat (20) @(negedge clk);
    chk("hold.total_accepts", 64'(acc_cnt - s_acc), 64'd2);

    // Reset dropped 100 clk into SDR
    tdo_mode = 2'd1;
    send("abort", IR_TRACECTRL, 38'h2A_AAAA_AAAA, 1'b0);
    model_last_ir = IR_TRACECTRL;
    exp_q.push_back('1);
    s_sdr = n_sdr;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      #1;
      if (n_sdr - s_sdr >= 100) begin ok = 1'b1; break; end
    end
    chk("abort.reach_sdr", 64'(ok), 64'd1);
    chk("abort.in_sdr", 64'(vji_sdr), 64'd1);
    s_rsp = n_rsp;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort.async");
    exp_q.delete();
    model_last_ir = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (400) @(negedge clk);
    #1;
    chk("abort.no_rsp", 64'(n_rsp - s_rsp), 64'd0);
    check_reset_outputs("abort.idle");

    // Fresh commands after the abort (IR 0 first: matches the reset IR)
    run_scan("post_abort0", IR_OCIMEM, 38'h3C_3C3C_3C3C, 2'd2, 38'h38_7878_7878);
    run_scan("post_abort1", IR_TRACEMEM, 38'h00_FFFF_0000, 2'd3, model_rx(38'h00_FFFF_0000, 2'd3));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
